uart_tx_fifo: RTL

//  Byte FIFO plus drain FSM between the debug/host logic and the UART Tx serializer. Producers

---
 rtl/uart_tx_fifo_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 25 ++
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART Tx byte FIFO: byte width, default depth and drain FSM states.
package uart_tx_fifo_pkg;

   localparam int UART_D_BIT    = 7;
   localparam int DEF_ADDR_BITS = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_RELEASE = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Pointer-addressed byte storage for the UART Tx FIFO: synchronous write, asynchronous read.
module uart_fifo_mem #(
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] w_addr,
   input  logic [DATA_BITS-1:0] w_data,
   input  logic [ADDR_BITS-1:0] r_addr,
   output logic [DATA_BITS-1:0] r_data
);

   logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[w_addr] <= w_data;
      end
   end

   // The drain FSM captures the head byte on the same edge it pops, so no read latency here.
   assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART Tx serializer over the tx_start/tx_done handshake.
// Optional UART_TX_FIFO_STATUS_EN adds the sticky overflow flag and the level output.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DATA_BITS = UART_D_BIT + 1,
   parameter int ADDR_BITS = DEF_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr,
   input  logic [DATA_BITS-1:0] w_data,
   input  logic                 tx_done,
   output logic                 tx_full,
   output logic                 tx_empty,
   output logic [DATA_BITS-1:0] tx_dato_in,
   output logic                 tx_start
`ifdef UART_TX_FIFO_STATUS_EN
   ,
   output logic                 overflow,
   output logic [ADDR_BITS:0]   level
`endif
);

   localparam int CW = ADDR_BITS + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(2**ADDR_BITS);

   logic [ADDR_BITS-1:0] wr_ptr_reg;
   logic [ADDR_BITS-1:0] rd_ptr_reg;
   logic [CW-1:0]        count_reg;
   logic [CW-1:0]        count_next;
   tx_state_e            state_reg;
   tx_state_e            state_next;
   logic                 tx_start_reg;
   logic                 tx_start_next;
   logic [DATA_BITS-1:0] tx_dato_reg;
   logic [DATA_BITS-1:0] tx_dato_next;
   logic [DATA_BITS-1:0] head_data;
   logic                 push;
   logic                 pop;

   assign tx_full    = (count_reg == FULL_COUNT);
   assign tx_empty   = (count_reg == '0);
   assign tx_start   = tx_start_reg;
   assign tx_dato_in = tx_dato_reg;

   // Full is judged on the registered count, so a same-cycle pop never admits a push.
   assign push = wr && !tx_full;

   uart_fifo_mem #(
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_mem (
      .clk    (clk),
      .we     (push),
      .w_addr (wr_ptr_reg),
      .w_data (w_data),
      .r_addr (rd_ptr_reg),
      .r_data (head_data)
   );

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         tx_start_reg <= 1'b0;
         tx_dato_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         tx_start_reg <= tx_start_next;
         tx_dato_reg  <= tx_dato_next;
      end
   end

   // RELEASE waits for tx_done to fall so one long done pulse completes only one byte.
   always_comb begin
      state_next    = state_reg;
      tx_start_next = tx_start_reg;
      tx_dato_next  = tx_dato_reg;
      pop           = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            tx_start_next = 1'b0;
            if (!tx_empty) begin
               pop           = 1'b1;
               tx_dato_next  = head_data;
               tx_start_next = 1'b1;
               state_next    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_done) begin
               tx_start_next = 1'b0;
               state_next    = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!tx_done) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            tx_start_next = 1'b0;
            state_next    = ST_IDLE;
         end
      endcase
   end

`ifdef UART_TX_FIFO_STATUS_EN
   logic overflow_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_reg <= 1'b0;
      end else if (wr && tx_full) begin
         overflow_reg <= 1'b1;
      end
   end

   assign overflow = overflow_reg;
   assign level    = count_reg;
`endif

endmodule
